// File: rtl/weight_update_engine.sv
// Weight update engine: buffers per-weight errors, requests the matching weights,
// computes sat(weight - error) in a fixed-latency pipeline, then streams all new weights out.
module weight_update_engine #(
   parameter int unsigned DATA_WIDTH  = 32,
   parameter int unsigned LAYER_WIDTH = 2,
   parameter int unsigned ADDR_WIDTH  = 11,
   parameter int unsigned NUM_LAYERS  = 3,
   parameter logic [NUM_LAYERS*ADDR_WIDTH-1:0] LAYER_DEPTHS = {11'd99, 11'd1056, 11'd96},
   parameter int unsigned PIPE_STAGES = 7
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   i_error_valid,
   input  logic [LAYER_WIDTH-1:0] i_error_layer,
   input  logic [ADDR_WIDTH-1:0]  i_error_addr,
   input  logic [DATA_WIDTH-1:0]  i_error,
   output logic                   o_weight_valid_request,
   output logic [LAYER_WIDTH-1:0] o_weight_layer_request,
   output logic [ADDR_WIDTH-1:0]  o_weight_addr_request,
   input  logic                   i_weight_valid,
   input  logic [LAYER_WIDTH-1:0] i_weight_layer,
   input  logic [ADDR_WIDTH-1:0]  i_weight_addr,
   input  logic [DATA_WIDTH-1:0]  i_weight,
   output logic                   o_new_weight_valid,
   input  logic                   i_new_weight_ready,
   output logic [LAYER_WIDTH-1:0] o_new_weight_layer,
   output logic [ADDR_WIDTH-1:0]  o_new_weight_addr,
   output logic [DATA_WIDTH-1:0]  o_new_weight,
   output logic                   o_busy,
   output logic                   o_update_done,
   output logic                   o_error_drop
);

   // Weight count of layer l (layers are 1-based; anything else has no weights)
   function automatic int unsigned depth_of(input int unsigned l);
      if (l == 0 || l > NUM_LAYERS) return 0;
      return 32'(LAYER_DEPTHS[(l-1)*ADDR_WIDTH +: ADDR_WIDTH]);
   endfunction

   // Flat base index of layer l (prefix sum of the lower layers)
   function automatic int unsigned base_of(input int unsigned l);
      int unsigned s;
      s = 0;
      for (int unsigned k = 1; k < l; k++) s += depth_of(k);
      return s;
   endfunction

   localparam int unsigned TOTAL = base_of(NUM_LAYERS + 1);
   localparam int unsigned IDX_W = (TOTAL > 1) ? $clog2(TOTAL) : 1;
   localparam int unsigned CNT_W = $clog2(TOTAL + 1);
   localparam int unsigned LAST  = PIPE_STAGES - 1;

   // Returns {legal, flat_index} for a layer/address pair
   function automatic logic [IDX_W:0] map_idx(input logic [LAYER_WIDTH-1:0] layer,
                                              input logic [ADDR_WIDTH-1:0]  addr);
      logic [IDX_W:0] r;
      r = '0;
      for (int unsigned l = 1; l <= NUM_LAYERS; l++) begin
         if (32'(layer) == l && 32'(addr) < depth_of(l))
            r = {1'b1, IDX_W'(base_of(l) + 32'(addr))};
      end
      return r;
   endfunction

   typedef enum logic {ACCUM, DRAIN} state_t;

   state_t state, state_nxt_c;

   logic [DATA_WIDTH-1:0] err_ram [TOTAL];
   logic [DATA_WIDTH-1:0] nw_ram  [TOTAL];

   logic [IDX_W:0]        e_map_c, w_map_c;
   logic                  e_legal_c, w_legal_c, err_we_c, w_take_c;

   logic [PIPE_STAGES-1:0] p_valid;
   logic [DATA_WIDTH-1:0]  p_w   [PIPE_STAGES];
   logic [DATA_WIDTH-1:0]  p_e   [PIPE_STAGES];
   logic [IDX_W-1:0]       p_idx [PIPE_STAGES];

   logic [DATA_WIDTH:0]   diff_c;
   logic [DATA_WIDTH-1:0] sat_c;
   logic                  wb_valid_c;
   logic [CNT_W-1:0]      cnt;

   logic [LAYER_WIDTH-1:0] rd_layer;
   logic [ADDR_WIDTH-1:0]  rd_addr;
   logic [IDX_W-1:0]       rd_idx;
   logic                   rd_left;
   logic                   rd_last_addr_c, rd_last_c, last_accept_c;

   logic busy_c, done_c, req_c, drop_c;

   assign e_map_c   = map_idx(i_error_layer, i_error_addr);
   assign w_map_c   = map_idx(i_weight_layer, i_weight_addr);
   assign e_legal_c = e_map_c[IDX_W];
   assign w_legal_c = w_map_c[IDX_W];
   assign err_we_c  = i_error_valid && e_legal_c && (state == ACCUM);
   assign w_take_c  = i_weight_valid && w_legal_c && (state == ACCUM);

   // Writeback: widen to DATA_WIDTH+1, subtract, clamp to the signed range
   assign wb_valid_c = p_valid[LAST] && (state == ACCUM);
   assign diff_c = {p_w[LAST][DATA_WIDTH-1], p_w[LAST]} - {p_e[LAST][DATA_WIDTH-1], p_e[LAST]};

   // Saturation of the widened difference
   always_comb begin
      sat_c = diff_c[DATA_WIDTH-1:0];
      if (diff_c[DATA_WIDTH] != diff_c[DATA_WIDTH-1])
         sat_c = diff_c[DATA_WIDTH] ? {1'b1, {(DATA_WIDTH-1){1'b0}}}
                                    : {1'b0, {(DATA_WIDTH-1){1'b1}}};
   end

   assign rd_last_addr_c = (32'(rd_addr) == depth_of(32'(rd_layer)) - 1);
   assign rd_last_c      = rd_last_addr_c && (32'(rd_layer) == NUM_LAYERS);
   assign last_accept_c  = (state == DRAIN) && o_new_weight_valid && i_new_weight_ready && !rd_left;

   // State register
   always_ff @(posedge clk) begin
      if (rst) state <= ACCUM;
      else     state <= state_nxt_c;
   end

   // Next state: enter DRAIN on the final writeback, leave after the last beat is taken
   always_comb begin
      state_nxt_c = state;
      case (state)
         ACCUM: if (wb_valid_c && cnt == CNT_W'(TOTAL - 1)) state_nxt_c = DRAIN;
         DRAIN: if (last_accept_c) state_nxt_c = ACCUM;
         default: state_nxt_c = ACCUM;
      endcase
   end

   // Next values of the registered status/request outputs
   always_comb begin
      busy_c = (state_nxt_c == DRAIN);
      done_c = last_accept_c;
      req_c  = err_we_c;
      drop_c = o_error_drop;
      if (i_error_valid && (!e_legal_c || state == DRAIN)) drop_c = 1'b1;
   end

   // Registered status and request outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         o_busy                 <= 1'b0;
         o_update_done          <= 1'b0;
         o_error_drop           <= 1'b0;
         o_weight_valid_request <= 1'b0;
         o_weight_layer_request <= '0;
         o_weight_addr_request  <= '0;
      end else begin
         o_busy                 <= busy_c;
         o_update_done          <= done_c;
         o_error_drop           <= drop_c;
         o_weight_valid_request <= req_c;
         if (req_c) begin
            o_weight_layer_request <= i_error_layer;
            o_weight_addr_request  <= i_error_addr;
         end
      end
   end

   // Error RAM write port
   always_ff @(posedge clk) begin
      if (err_we_c) err_ram[e_map_c[IDX_W-1:0]] <= i_error;
   end

   // Pipeline valids; anything in flight is discarded while draining
   always_ff @(posedge clk) begin
      if (rst || state == DRAIN) begin
         p_valid <= '0;
      end else begin
         p_valid[0] <= w_take_c;
         for (int unsigned i = 1; i < PIPE_STAGES; i++) p_valid[i] <= p_valid[i-1];
      end
   end

   // Pipeline payload; the error RAM read returns the pre-write value on a same-index collision
   always_ff @(posedge clk) begin
      p_w[0]   <= i_weight;
      p_e[0]   <= err_ram[w_map_c[IDX_W-1:0]];
      p_idx[0] <= w_map_c[IDX_W-1:0];
      for (int unsigned i = 1; i < PIPE_STAGES; i++) begin
         p_w[i]   <= p_w[i-1];
         p_e[i]   <= p_e[i-1];
         p_idx[i] <= p_idx[i-1];
      end
   end

   // New-weight RAM write port
   always_ff @(posedge clk) begin
      if (wb_valid_c) nw_ram[p_idx[LAST]] <= sat_c;
   end

   // Update counter, one step per writeback, cleared when the round completes
   always_ff @(posedge clk) begin
      if (rst)             cnt <= '0;
      else if (wb_valid_c) cnt <= (cnt == CNT_W'(TOTAL - 1)) ? '0 : cnt + CNT_W'(1);
   end

   // Output stream: load the next beat whenever the output slot is empty or being taken
   always_ff @(posedge clk) begin
      if (rst) begin
         o_new_weight_valid <= 1'b0;
         o_new_weight_layer <= '0;
         o_new_weight_addr  <= '0;
         o_new_weight       <= '0;
         rd_layer           <= '0;
         rd_addr            <= '0;
         rd_idx             <= '0;
         rd_left            <= 1'b0;
      end else if (state == ACCUM) begin
         o_new_weight_valid <= 1'b0;
         if (state_nxt_c == DRAIN) begin
            rd_layer <= LAYER_WIDTH'(1);
            rd_addr  <= '0;
            rd_idx   <= '0;
            rd_left  <= 1'b1;
         end
      end else if (!o_new_weight_valid || i_new_weight_ready) begin
         if (rd_left) begin
            o_new_weight_valid <= 1'b1;
            o_new_weight_layer <= rd_layer;
            o_new_weight_addr  <= rd_addr;
            o_new_weight       <= nw_ram[rd_idx];
            rd_idx             <= rd_idx + IDX_W'(1);
            rd_left            <= !rd_last_c;
            if (rd_last_addr_c) begin
               rd_layer <= rd_layer + LAYER_WIDTH'(1);
               rd_addr  <= '0;
            end else begin
               rd_addr  <= rd_addr + ADDR_WIDTH'(1);
            end
         end else begin
            o_new_weight_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_weight_update_engine.sv
// Directed bench for weight_update_engine: 2 layers (L1=4, L2=3), 16-bit data, 3-stage pipe.
module tb_weight_update_engine;

   localparam int unsigned DW = 16;
   localparam int unsigned LW = 2;
   localparam int unsigned AW = 3;
   localparam int unsigned NL = 2;
   localparam int unsigned PS = 3;
   localparam logic [NL*AW-1:0] DEPTHS = {3'd3, 3'd4};

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          i_error_valid = 1'b0;
   logic [LW-1:0] i_error_layer = '0;
   logic [AW-1:0] i_error_addr = '0;
   logic [DW-1:0] i_error = '0;
   logic          o_weight_valid_request;
   logic [LW-1:0] o_weight_layer_request;
   logic [AW-1:0] o_weight_addr_request;
   logic          i_weight_valid = 1'b0;
   logic [LW-1:0] i_weight_layer = '0;
   logic [AW-1:0] i_weight_addr = '0;
   logic [DW-1:0] i_weight = '0;
   logic          o_new_weight_valid;
   logic          i_new_weight_ready = 1'b1;
   logic [LW-1:0] o_new_weight_layer;
   logic [AW-1:0] o_new_weight_addr;
   logic [DW-1:0] o_new_weight;
   logic          o_busy;
   logic          o_update_done;
   logic          o_error_drop;

   int total = 0;
   int bad   = 0;

   logic [DW-1:0] exp_nw [7];
   logic [DW-1:0] err_v  [7];
   logic [DW-1:0] w_v    [7];
   logic          pat    [8];

   weight_update_engine #(
      .DATA_WIDTH(DW), .LAYER_WIDTH(LW), .ADDR_WIDTH(AW),
      .NUM_LAYERS(NL), .LAYER_DEPTHS(DEPTHS), .PIPE_STAGES(PS)
   ) dut (
      .clk(clk), .rst(rst),
      .i_error_valid(i_error_valid), .i_error_layer(i_error_layer),
      .i_error_addr(i_error_addr), .i_error(i_error),
      .o_weight_valid_request(o_weight_valid_request),
      .o_weight_layer_request(o_weight_layer_request),
      .o_weight_addr_request(o_weight_addr_request),
      .i_weight_valid(i_weight_valid), .i_weight_layer(i_weight_layer),
      .i_weight_addr(i_weight_addr), .i_weight(i_weight),
      .o_new_weight_valid(o_new_weight_valid), .i_new_weight_ready(i_new_weight_ready),
      .o_new_weight_layer(o_new_weight_layer), .o_new_weight_addr(o_new_weight_addr),
      .o_new_weight(o_new_weight),
      .o_busy(o_busy), .o_update_done(o_update_done), .o_error_drop(o_error_drop)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic idle();
      i_error_valid  = 1'b0;
      i_weight_valid = 1'b0;
   endtask

   function automatic logic [LW-1:0] lay_of(input int b);
      return (b < 4) ? LW'(1) : LW'(2);
   endfunction

   function automatic logic [AW-1:0] adr_of(input int b);
      return (b < 4) ? AW'(b) : AW'(b - 4);
   endfunction

   function automatic logic [31:0] outs_all();
      return 32'({o_weight_valid_request, o_weight_layer_request, o_weight_addr_request,
                  o_new_weight_valid, o_new_weight_layer, o_new_weight_addr, o_new_weight,
                  o_busy, o_update_done, o_error_drop});
   endfunction

   function automatic logic [31:0] beat_obs();
      return 32'({o_new_weight_valid, o_new_weight_layer, o_new_weight_addr, o_new_weight});
   endfunction

   function automatic logic [31:0] beat_exp(input int b);
      return 32'({1'b1, lay_of(b), adr_of(b), exp_nw[b]});
   endfunction

   task automatic err_wr(input logic [LW-1:0] l, input logic [AW-1:0] a, input logic [DW-1:0] v);
      i_error_valid = 1'b1; i_error_layer = l; i_error_addr = a; i_error = v;
   endtask

   task automatic resp(input logic [LW-1:0] l, input logic [AW-1:0] a, input logic [DW-1:0] w);
      i_weight_valid = 1'b1; i_weight_layer = l; i_weight_addr = a; i_weight = w;
   endtask

   // Called right after the edge that sampled the final response
   task automatic wait_entry();
      idle();
      tick();
      tick();
      chk("busy_before_wb", 32'(o_busy), 32'd0);
      tick();
      chk("busy_at_wb", 32'(o_busy), 32'd1);
      chk("valid_at_entry", 32'(o_new_weight_valid), 32'd0);
   endtask

   // Walk the output stream; stop_after >= 0 returns while that beat is presented
   task automatic drain(input bit bp, input int stop_after);
      int b;
      int c;
      logic rdy;
      b = 0;
      c = 0;
      tick();
      idle();
      chk("no_req_in_drain", 32'(o_weight_valid_request), 32'd0);
      chk("beat", beat_obs(), beat_exp(0));
      while (b < 7 && c < 40) begin
         if (b == stop_after) return;
         rdy = bp ? pat[c % 8] : 1'b1;
         i_new_weight_ready = rdy;
         tick();
         c++;
         if (rdy) b++;
         if (b < 7) begin
            chk("beat", beat_obs(), beat_exp(b));
            chk("done_mid", 32'(o_update_done), 32'd0);
         end
      end
      chk("drain_finished", 32'(b), 32'd7);
      chk("end_valid_done_busy", 32'({o_new_weight_valid, o_update_done, o_busy}), 32'b010);
      i_new_weight_ready = 1'b1;
      tick();
      chk("done_one_cycle", 32'(o_update_done), 32'd0);
   endtask

   initial begin
      pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
      err_v = '{16'hFF00, 16'h0100, 16'h0010, 16'h0001, 16'hFFFF, 16'h8000, 16'h0001};
      w_v   = '{16'h7FF0, 16'h8010, 16'h0100, 16'h0000, 16'h1234, 16'h0000, 16'h8001};

      // Reset
      tick(); tick();
      chk("reset_outputs", outs_all(), 32'd0);
      rst = 1'b0;
      tick();
      chk("after_reset", outs_all(), 32'd0);

      // Round 1: back-to-back legal error writes, each answered by a request one cycle later
      for (int b = 0; b < 7; b++) begin
         err_wr(lay_of(b), adr_of(b), err_v[b]);
         tick();
         chk("req", 32'({o_weight_valid_request, o_weight_layer_request, o_weight_addr_request}),
             32'({1'b1, lay_of(b), adr_of(b)}));
      end
      idle();
      tick();
      chk("req_drops", 32'(o_weight_valid_request), 32'd0);
      chk("drop_clear", 32'(o_error_drop), 32'd0);

      // Illegal error writes: layer 0, layer 3, layer 2 addr 3
      err_wr(LW'(0), AW'(0), 16'h1111); tick();
      chk("req_ill_l0", 32'(o_weight_valid_request), 32'd0);
      chk("drop_set", 32'(o_error_drop), 32'd1);
      err_wr(LW'(3), AW'(0), 16'h2222); tick();
      chk("req_ill_l3", 32'(o_weight_valid_request), 32'd0);
      err_wr(LW'(2), AW'(3), 16'h3333); tick();
      chk("req_ill_a3", 32'(o_weight_valid_request), 32'd0);
      idle();

      // Illegal weight responses must not count toward the round
      resp(LW'(0), AW'(0), 16'h0000); tick();
      resp(LW'(3), AW'(1), 16'h0000); tick();
      resp(LW'(2), AW'(3), 16'h0000); tick();

      // Legal responses, including saturation at both ends and an exact minimum
      for (int b = 0; b < 7; b++) begin
         resp(lay_of(b), adr_of(b), w_v[b]);
         tick();
      end
      wait_entry();
      exp_nw = '{16'h7FFF, 16'h8000, 16'h00F0, 16'hFFFF, 16'h1235, 16'h7FFF, 16'h8000};
      i_new_weight_ready = 1'b1;
      drain(1'b0, -1);

      // Round 2: reverse order, zero weights, same-index error write collides with a response
      for (int b = 6; b >= 0; b--) begin
         resp(lay_of(b), adr_of(b), 16'h0000);
         if (b == 2) err_wr(LW'(1), AW'(2), 16'h0020);
         tick();
         i_error_valid = 1'b0;
         if (b == 2)
            chk("req_collide", 32'({o_weight_valid_request, o_weight_layer_request, o_weight_addr_request}),
                32'({1'b1, LW'(1), AW'(2)}));
      end
      wait_entry();
      exp_nw = '{16'h0100, 16'hFF00, 16'hFFF0, 16'hFFFF, 16'h0001, 16'h7FFF, 16'hFFFF};
      drain(1'b1, -1);
      chk("drop_sticky", 32'(o_error_drop), 32'd1);

      // Round 3: reset while beat 3 is on the bus
      for (int b = 0; b < 7; b++) begin
         resp(lay_of(b), adr_of(b), 16'h0100);
         tick();
      end
      wait_entry();
      exp_nw = '{16'h0200, 16'h0000, 16'h00E0, 16'h00FF, 16'h0101, 16'h7FFF, 16'h00FF};
      i_new_weight_ready = 1'b1;
      drain(1'b0, 3);
      rst = 1'b1;
      tick();
      chk("mid_drain_reset", outs_all(), 32'd0);
      rst = 1'b0;
      tick();

      // Round 4: fresh round; error and weight arriving during DRAIN are discarded
      for (int b = 0; b < 7; b++) begin
         resp(lay_of(b), adr_of(b), 16'h0000);
         tick();
      end
      wait_entry();
      exp_nw = '{16'h0100, 16'hFF00, 16'hFFE0, 16'hFFFF, 16'h0001, 16'h7FFF, 16'hFFFF};
      err_wr(LW'(1), AW'(0), 16'h7777);
      resp(LW'(1), AW'(1), 16'h0000);
      drain(1'b0, -1);
      chk("drop_in_drain", 32'(o_error_drop), 32'd1);

      // Round 5: six responses must not complete a round (the DRAIN-time response was not counted)
      for (int b = 0; b < 6; b++) begin
         resp(lay_of(b), adr_of(b), 16'h0000);
         tick();
      end
      idle();
      for (int i = 0; i < 5; i++) tick();
      chk("no_early_drain", 32'(o_busy), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/weight_update_engine.md
Name: weight_update_engine

Overview:
- Parametrised successor to the fixed three-layer main-net weight updater.
- Buffers per-weight errors for NUM_LAYERS weight layers and issues a weight-read request for each stored error.
- Computes new_weight = sat(weight − error) in a PIPE_STAGES-deep fixed-point pipeline and stores the results.
- Once every weight has been updated, streams all new weights out in layer/address order over a ready/valid handshake. Sits between the backprop error generator and the main-net weight memory.

Parameters:
- DATA_WIDTH, 32, signed two's-complement weight/error width.
- LAYER_WIDTH, 2, layer index width; must satisfy 2^LAYER_WIDTH > NUM_LAYERS.
- ADDR_WIDTH, 11, per-layer weight address width.
- NUM_LAYERS, 3, number of weight layers; layer indices are 1..NUM_LAYERS, and index 0 (input) carries no weights.
- LAYER_DEPTHS, {11'd99,11'd1056,11'd96}, packed NUM_LAYERS*ADDR_WIDTH vector of per-layer weight counts; layer 1 occupies the LSBs. Each count is in 1..2^ADDR_WIDTH−1.
- PIPE_STAGES, 7, subtract pipeline latency in cycles (≥1).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- i_error_valid  in  1  error write strobe
- i_error_layer  in  LAYER_WIDTH  error layer
- i_error_addr  in  ADDR_WIDTH  error address
- i_error  in  DATA_WIDTH  error value (already learning-rate scaled)
- o_weight_valid_request  out  1  weight read request pulse
- o_weight_layer_request  out  LAYER_WIDTH  requested layer
- o_weight_addr_request  out  ADDR_WIDTH  requested address
- i_weight_valid  in  1  weight response strobe
- i_weight_layer  in  LAYER_WIDTH  response layer
- i_weight_addr  in  ADDR_WIDTH  response address
- i_weight  in  DATA_WIDTH  current weight
- o_new_weight_valid  out  1  output stream valid
- i_new_weight_ready  in  1  output stream ready
- o_new_weight_layer  out  LAYER_WIDTH  output layer
- o_new_weight_addr  out  ADDR_WIDTH  output address
- o_new_weight  out  DATA_WIDTH  updated weight
- o_busy  out  1  high while in DRAIN
- o_update_done  out  1  one-cycle pulse after the last output beat
- o_error_drop  out  1  sticky flag: an error write was discarded

Behaviour:
- Reset: all outputs 0, state ACCUM, update counter 0, pipeline valids cleared. RAM contents are not reset. Reset mid-DRAIN aborts the stream; o_new_weight_valid is 0 on the next cycle.
- Storage:
  - Error RAM and new-weight RAM are each flat, with depth TOTAL = sum(LAYER_DEPTHS).
  - Flat index = base(layer) + addr, where base is the prefix sum computed at elaboration.
- Legal access: 1 ≤ layer ≤ NUM_LAYERS and addr < depth(layer). Illegal error writes and illegal weight responses are ignored with no request and no count; an illegal error write also sets o_error_drop.
- ACCUM state, error path:
  - A legal i_error_valid writes the error RAM.
  - The next cycle it raises o_weight_valid_request for exactly 1 cycle, with the same layer/addr.
  - Back-to-back errors give back-to-back requests.
- ACCUM state, weight path:
  - A legal i_weight_valid reads the error at the same index.
  - The sum new = weight − error is computed at DATA_WIDTH+1 bits, then saturated to [−2^(DATA_WIDTH−1), 2^(DATA_WIDTH−1)−1].
  - The result is written to the new-weight RAM PIPE_STAGES cycles after i_weight_valid.
  - Layer/addr travel through a matching delay line.
- Simultaneous error write and weight response are both serviced (dual-port error RAM). If both target the same index in the same cycle, the read returns the old value.
- Counter: each pipeline writeback increments the update counter, including duplicate addresses (no dedupe). On the writeback where the counter reaches TOTAL, the counter clears and the state moves to DRAIN on the next cycle.
- DRAIN state:
  - o_busy = 1.
  - The block streams layer 1 addr 0 … depth−1, then layer 2, through layer NUM_LAYERS, with one beat per accepted handshake.
  - While o_new_weight_valid=1 and i_new_weight_ready=0, valid, layer, addr and data are held stable.
  - Full throughput is 1 beat/cycle when ready is held high.
  - Errors arriving during DRAIN are dropped and set o_error_drop; no requests are issued.
  - Weight responses during DRAIN are ignored. Pipeline results still in flight at DRAIN entry are discarded.
- End of DRAIN: the cycle after the final beat (last layer, addr depth−1) is accepted, valid drops, o_update_done pulses for 1 cycle, and the state returns to ACCUM. The next update round starts immediately.

Test Plan:
Bench parameters: NUM_LAYERS=2, LAYER_DEPTHS={3,4} (L1=4, L2=3), DATA_WIDTH=16, PIPE_STAGES=3.
- Error write L1 addr 2 value 0x0010 → request pulse at cycle+1 with layer 1, addr 2. Respond with weight 0x0100 → writeback 0x00F0 three cycles later.
- Saturation: weight 0x7FF0, error 0xFF00 (−256) → 0x7FFF. Weight 0x8010, error 0x0100 → 0x8000.
- Seven legal updates with ready=1 → o_busy rises; 7 beats in order (1,0)(1,1)(1,2)(1,3)(2,0)(2,1)(2,2); o_update_done pulses once, the cycle after the last beat.
- Backpressure: ready toggles 1,0,0,1 during DRAIN → no beat lost or duplicated, and data is stable across stalls.
- Illegal accesses (L0, L3, L2 addr 3) plus errors written during DRAIN → no requests, no count increment, o_error_drop=1 until rst.
- Assert rst mid-DRAIN after beat 3 → next cycle all outputs 0 and state ACCUM; a fresh 7-update round then drains correctly.
